// File: rtl/frame_buffer_ctrl.sv
// Single-clock frame buffer: one draw-side write port shared with a fill engine,
// and a raster-scan read port with integer pixel scaling and 2-cycle latency.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | user writes accepted; clear_req starts a fill
// ST_CLEAR | fill engine owns the write port, one pixel per cycle
module frame_buffer_ctrl #(
  parameter int COLOR_CHANNEL_DEPTH = 1,
  parameter int X_RES               = 160,
  parameter int Y_RES               = 120,
  parameter int X_W                 = 8,
  parameter int Y_W                 = 7,
  parameter int SCALE_LOG2          = 2
) (
  input  logic                             CLOCK_50,
  input  logic                             resetn,
  input  logic [X_W-1:0]                   x,
  input  logic [Y_W-1:0]                   y,
  input  logic [3*COLOR_CHANNEL_DEPTH-1:0] color,
  input  logic                             writeEn,
  input  logic                             clear_req,
  input  logic [3*COLOR_CHANNEL_DEPTH-1:0] clear_color,
  output logic                             clear_busy,
  output logic                             clear_done,
  input  logic                             scan_en,
  output logic [3*COLOR_CHANNEL_DEPTH-1:0] rd_color,
  output logic                             rd_valid,
  output logic                             rd_frame_start
);

  localparam int PIX_W = 3*COLOR_CHANNEL_DEPTH;
  localparam int AW    = X_W + Y_W;
  localparam int DEPTH = 2**AW;
  localparam int SXW   = X_W + SCALE_LOG2;
  localparam int SYW   = Y_W + SCALE_LOG2;

  localparam logic [X_W:0]     X_LIM   = (X_W+1)'(X_RES);
  localparam logic [Y_W:0]     Y_LIM   = (Y_W+1)'(Y_RES);
  localparam logic [X_W-1:0]   CX_LAST = X_W'(X_RES - 1);
  localparam logic [Y_W-1:0]   CY_LAST = Y_W'(Y_RES - 1);
  localparam logic [SXW-1:0]   SX_LAST = SXW'((X_RES << SCALE_LOG2) - 1);
  localparam logic [SYW-1:0]   SY_LAST = SYW'((Y_RES << SCALE_LOG2) - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t            state_q, state_d;
  logic [X_W-1:0]    cx_q, cx_d;
  logic [Y_W-1:0]    cy_q, cy_d;
  logic [PIX_W-1:0]  clr_color_q, clr_color_d;
  logic              done_q, done_d;
  logic              clear_last;
  logic              clear_start;
  logic              busy;

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [PIX_W-1:0]  wr_data;

  logic [PIX_W-1:0]  mem [DEPTH];

  logic [SXW-1:0]    sx_q, sx_d;
  logic [SYW-1:0]    sy_q, sy_d;
  logic [AW-1:0]     rd_addr_q, rd_addr_d;
  logic              v1_q, fs1_q, fs1_d;
  logic              rd_valid_q, rd_fs_q;
  logic [PIX_W-1:0]  rd_color_q;

  assign clear_last = (cx_q == CX_LAST) && (cy_q == CY_LAST);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (clear_req)  state_d = ST_CLEAR;
      ST_CLEAR: if (clear_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // In CLEAR the user port is ignored outright, nothing is queued.
  always_comb begin
    busy        = 1'b0;
    clear_start = 1'b0;
    done_d      = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = {y, x};
    wr_data     = color;
    case (state_q)
      ST_IDLE: begin
        wr_en       = writeEn && ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);
        clear_start = clear_req;
      end
      ST_CLEAR: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = {cy_q, cx_q};
        wr_data = clr_color_q;
        done_d  = clear_last;
      end
      default: ;
    endcase
  end

  always_comb begin
    cx_d        = cx_q;
    cy_d        = cy_q;
    clr_color_d = clr_color_q;
    if (clear_start) begin
      cx_d        = '0;
      cy_d        = '0;
      clr_color_d = clear_color;
    end else if (busy) begin
      if (cx_q == CX_LAST) begin
        cx_d = '0;
        cy_d = cy_q + 1'b1;
      end else begin
        cx_d = cx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cx_q        <= '0;
      cy_q        <= '0;
      clr_color_q <= '0;
      done_q      <= 1'b0;
    end else begin
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      clr_color_q <= clr_color_d;
      done_q      <= done_d;
    end
  end

  assign clear_busy = busy;
  assign clear_done = done_q;

  always_ff @(posedge CLOCK_50) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    sx_d = sx_q;
    sy_d = sy_q;
    if (scan_en) begin
      if (sx_q == SX_LAST) begin
        sx_d = '0;
        sy_d = (sy_q == SY_LAST) ? '0 : sy_q + 1'b1;
      end else begin
        sx_d = sx_q + 1'b1;
      end
    end
  end

  // Dropping the low SCALE_LOG2 bits repeats each stored pixel in x and y.
  assign rd_addr_d = {sy_q[SYW-1 -: Y_W], sx_q[SXW-1 -: X_W]};
  assign fs1_d     = scan_en && (sx_q == '0) && (sy_q == '0);

  // The data stage reads the array in the same edge a write may land, so a
  // colliding address returns the old contents.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sx_q       <= '0;
      sy_q       <= '0;
      rd_addr_q  <= '0;
      v1_q       <= 1'b0;
      fs1_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_fs_q    <= 1'b0;
      rd_color_q <= '0;
    end else begin
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      rd_addr_q  <= rd_addr_d;
      v1_q       <= scan_en;
      fs1_q      <= fs1_d;
      rd_valid_q <= v1_q;
      rd_fs_q    <= fs1_q;
      if (v1_q) rd_color_q <= mem[rd_addr_q];
    end
  end

  assign rd_color       = rd_color_q;
  assign rd_valid       = rd_valid_q;
  assign rd_frame_start = rd_fs_q;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Self-checking bench for frame_buffer_ctrl, built on a reduced geometry
// (40x30, 2x scaling) so full frames and full clears stay short.
module tb_frame_buffer_ctrl;

  localparam int XR    = 40;
  localparam int YR    = 30;
  localparam int XW    = 6;
  localparam int YW    = 5;
  localparam int SL    = 1;
  localparam int SXN   = XR << SL;
  localparam int SYN   = YR << SL;
  localparam int FRAME = SXN * SYN;
  localparam int NPIX  = XR * YR;
  localparam int ABORT_AT = 500;

  logic          CLOCK_50 = 1'b0;
  logic          resetn = 1'b0;
  logic [XW-1:0] x = '0;
  logic [YW-1:0] y = '0;
  logic [2:0]    color = '0;
  logic          writeEn = 1'b0;
  logic          clear_req = 1'b0;
  logic [2:0]    clear_color = '0;
  logic          clear_busy, clear_done;
  logic          scan_en = 1'b0;
  logic [2:0]    rd_color;
  logic          rd_valid, rd_frame_start;

  frame_buffer_ctrl #(
    .COLOR_CHANNEL_DEPTH(1), .X_RES(XR), .Y_RES(YR),
    .X_W(XW), .Y_W(YW), .SCALE_LOG2(SL)
  ) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .x(x), .y(y), .color(color),
    .writeEn(writeEn), .clear_req(clear_req), .clear_color(clear_color),
    .clear_busy(clear_busy), .clear_done(clear_done), .scan_en(scan_en),
    .rd_color(rd_color), .rd_valid(rd_valid), .rd_frame_start(rd_frame_start)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;

  logic [2:0] model [NPIX];
  int msx = 0;
  int msy = 0;

  typedef struct {
    int         due;
    logic [2:0] col;
    logic       fs;
    int         px;
    int         py;
  } sb_t;
  sb_t sbq[$];
  logic [2:0] last_col = '0;
  int fs_cnt = 0;
  int fs_cyc[$];

  typedef struct {
    logic [XW-1:0] wx;
    logic [YW-1:0] wy;
    logic [2:0]    wc;
    bit            lands;
  } wvec_t;
  wvec_t wv[9];

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sb_check();
    sb_t e;
    bit  ev;
    ev = (sbq.size() > 0) && (sbq[0].due == cyc);
    chk("rd_valid", int'(rd_valid), int'(ev));
    if (ev) begin
      e = sbq.pop_front();
      ntests++;
      if (rd_color !== e.col || rd_frame_start !== e.fs) begin
        nfail++;
        $display("FAIL scan(%0d,%0d): rd_color=%0d fs=%0d expected rd_color=%0d fs=%0d",
                 e.px, e.py, rd_color, rd_frame_start, e.col, e.fs);
      end
      last_col = e.col;
    end else begin
      chk("rd_color_hold", int'(rd_color), int'(last_col));
      chk("rd_frame_start_idle", int'(rd_frame_start), 0);
    end
    if (rd_frame_start) begin
      fs_cnt++;
      fs_cyc.push_back(cyc);
    end
  endtask

  task automatic scan(input int n, input bit en);
    for (int i = 0; i < n; i++) begin
      scan_en = en;
      if (en) begin
        sb_t e;
        e.due = cyc + 2;
        e.px  = msx >> SL;
        e.py  = msy >> SL;
        e.col = model[e.py*XR + e.px];
        e.fs  = (msx == 0) && (msy == 0);
        sbq.push_back(e);
        msx++;
        if (msx == SXN) begin
          msx = 0;
          msy++;
          if (msy == SYN) msy = 0;
        end
      end
      tick();
      sb_check();
    end
    scan_en = 1'b0;
  endtask

  task automatic scan_frame();
    scan(FRAME, 1'b1);
    scan(3, 1'b0);
  endtask

  task automatic run_clear(input logic [2:0] c, input bit hold_we, input bit mid_req,
                           input string tag);
    int busy_n, done_n, first_busy, first_done;
    busy_n = 0; done_n = 0; first_busy = -1; first_done = -1;
    chk({tag, "_busy_idle"}, int'(clear_busy), 0);
    clear_color = c;
    clear_req   = 1'b1;
    tick();
    clear_req   = 1'b0;
    clear_color = 3'b000;
    for (int i = 0; i < NPIX + 6; i++) begin
      if (clear_busy) begin
        busy_n++;
        if (first_busy < 0) first_busy = i;
      end
      if (clear_done) begin
        done_n++;
        if (first_done < 0) first_done = i;
      end
      writeEn     = hold_we && (i < NPIX - 1);
      x           = '0;
      y           = '0;
      color       = 3'b111;
      clear_req   = mid_req && (i == NPIX/2);
      clear_color = mid_req ? 3'b100 : 3'b000;
      tick();
    end
    writeEn   = 1'b0;
    clear_req = 1'b0;
    chk({tag, "_busy_cycles"}, busy_n, NPIX);
    chk({tag, "_busy_first"}, first_busy, 0);
    chk({tag, "_done_pulses"}, done_n, 1);
    chk({tag, "_done_at"}, first_done, NPIX);
    for (int k = 0; k < NPIX; k++) model[k] = c;
  endtask

  initial begin
    wv[0] = '{wx: 6'd5,  wy: 5'd7,  wc: 3'b101, lands: 1'b1};
    wv[1] = '{wx: 6'd6,  wy: 5'd7,  wc: 3'b010, lands: 1'b1};
    wv[2] = '{wx: 6'd0,  wy: 5'd0,  wc: 3'b110, lands: 1'b1};
    wv[3] = '{wx: 6'd39, wy: 5'd29, wc: 3'b011, lands: 1'b1};
    wv[4] = '{wx: 6'd39, wy: 5'd0,  wc: 3'b111, lands: 1'b1};
    wv[5] = '{wx: 6'd0,  wy: 5'd29, wc: 3'b100, lands: 1'b1};
    wv[6] = '{wx: 6'd40, wy: 5'd10, wc: 3'b111, lands: 1'b0};
    wv[7] = '{wx: 6'd3,  wy: 5'd30, wc: 3'b111, lands: 1'b0};
    wv[8] = '{wx: 6'd63, wy: 5'd31, wc: 3'b001, lands: 1'b0};

    for (int k = 0; k < NPIX; k++) model[k] = 3'b000;

    // Reset values
    tick(); tick();
    chk("rst_clear_busy", int'(clear_busy), 0);
    chk("rst_clear_done", int'(clear_done), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_frame_start", int'(rd_frame_start), 0);
    chk("rst_rd_color", int'(rd_color), 0);
    resetn = 1'b1;
    tick();

    // Known starting contents
    run_clear(3'b000, 1'b0, 1'b0, "init_clear");

    // Table-driven writes, including out-of-range coordinates, then full readback
    for (int i = 0; i < 9; i++) begin
      x = wv[i].wx; y = wv[i].wy; color = wv[i].wc; writeEn = 1'b1;
      tick();
      writeEn = 1'b0;
      chk("write_busy", int'(clear_busy), 0);
      if (wv[i].lands) model[int'(wv[i].wy)*XR + int'(wv[i].wx)] = wv[i].wc;
    end
    scan_frame();

    // Full clear to 010, then every pixel reads the fill colour
    run_clear(3'b010, 1'b0, 1'b0, "clear010");
    scan_frame();

    // Clear with user writes held at (0,0) and a second request mid-clear
    run_clear(3'b011, 1'b1, 1'b1, "clear_blocked");
    scan_frame();

    // Two continuous frames, then a scan pause and resume
    fs_cnt = 0;
    fs_cyc.delete();
    scan(2*FRAME, 1'b1);
    scan(3, 1'b0);
    chk("fs_pulses", fs_cnt, 2);
    if (fs_cyc.size() == 2) chk("fs_spacing", fs_cyc[1] - fs_cyc[0], FRAME);
    else                    chk("fs_count_for_spacing", fs_cyc.size(), 2);
    scan(37, 1'b1);
    scan(10, 1'b0);
    scan(50, 1'b1);
    scan(3, 1'b0);

    // Reset part-way through a clear
    clear_color = 3'b110;
    clear_req   = 1'b1;
    tick();
    clear_req   = 1'b0;
    clear_color = 3'b000;
    for (int i = 0; i < ABORT_AT; i++) tick();
    chk("abort_busy_before", int'(clear_busy), 1);
    resetn = 1'b0;
    #1;
    chk("abort_clear_busy", int'(clear_busy), 0);
    chk("abort_clear_done", int'(clear_done), 0);
    chk("abort_rd_valid", int'(rd_valid), 0);
    chk("abort_rd_color", int'(rd_color), 0);
    for (int k = 0; k < ABORT_AT; k++) model[k] = 3'b110;
    tick(); tick();
    resetn = 1'b1;
    msx = 0;
    msy = 0;
    sbq.delete();
    last_col = 3'b000;
    tick();
    chk("post_abort_busy", int'(clear_busy), 0);
    scan_frame();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
